// File: rtl/apb_pkg.sv
// Shared types and helpers for the APB requester and its timeout counter.
package apb_pkg;

  typedef enum logic [1:0] {
    IDLE,
    SETUP,
    ACCESS,
    RESP
  } apb_state_e;

  typedef logic [2:0] apb_prot_t;

  localparam int unsigned PROT_PRIVILEGED = 0;
  localparam int unsigned PROT_NONSECURE  = 1;
  localparam int unsigned PROT_INSTRUCTION = 2;

  // Wide enough to hold the value TIMEOUT_CYCLES itself; at least one bit.
  function automatic int unsigned timeout_cnt_width(input int unsigned limit);
    return (limit == 0) ? 1 : $clog2(limit + 1);
  endfunction

endpackage

// File: rtl/apb_timeout_cnt.sv
// Saturating wait-state counter; expired fires while enabled once the count has reached limit.
module apb_timeout_cnt
  import apb_pkg::*;
#(
  parameter int unsigned TIMEOUT_CYCLES = 256,
  parameter int unsigned CNT_WIDTH      = timeout_cnt_width(TIMEOUT_CYCLES)
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 clear,
  input  logic                 enable,
  input  logic [CNT_WIDTH-1:0] limit,
  output logic                 expired
);

  if (TIMEOUT_CYCLES == 0) begin : g_no_timeout
    assign expired = 1'b0;
  end else begin : g_timeout
    logic [CNT_WIDTH-1:0] cnt_q, cnt_d;
    logic                 at_limit;

    assign at_limit = (cnt_q >= limit);
    assign expired  = enable && at_limit;

    // Stops at the limit so the count can never wrap back to zero.
    always_comb begin
      cnt_d = cnt_q;
      if (clear) begin
        cnt_d = '0;
      end else if (enable && !at_limit) begin
        cnt_d = cnt_q + 1'b1;
      end
    end

    always_ff @(posedge clk) begin
      if (!rst_n) begin
        cnt_q <= '0;
      end else begin
        cnt_q <= cnt_d;
      end
    end
  end

endmodule

// File: rtl/apb_requester.sv
// APB4 requester: turns a valid/ready command into one SETUP/ACCESS transfer and
// returns the result on a valid/ready response channel. One transfer in flight.
module apb_requester
  import apb_pkg::*;
#(
  parameter int unsigned ADDR_WIDTH     = 32,
  parameter int unsigned DATA_WIDTH     = 32,
  parameter int unsigned TIMEOUT_CYCLES = 256
) (
  input  logic                    PCLK,
  input  logic                    PRESETn,
  input  logic                    cmd_valid,
  output logic                    cmd_ready,
  input  logic                    cmd_write,
  input  logic [ADDR_WIDTH-1:0]   cmd_addr,
  input  logic [DATA_WIDTH-1:0]   cmd_wdata,
  input  logic [DATA_WIDTH/8-1:0] cmd_strb,
  input  logic [2:0]              cmd_prot,
  output logic                    rsp_valid,
  input  logic                    rsp_ready,
  output logic [DATA_WIDTH-1:0]   rsp_rdata,
  output logic                    rsp_err,
  output logic                    rsp_timeout,
  output logic [ADDR_WIDTH-1:0]   PADDR,
  output logic                    PSEL,
  output logic                    PENABLE,
  output logic                    PWRITE,
  output logic [DATA_WIDTH-1:0]   PWDATA,
  output logic [DATA_WIDTH/8-1:0] PSTRB,
  output logic [2:0]              PPROT,
  input  logic [DATA_WIDTH-1:0]   PRDATA,
  input  logic                    PREADY,
  input  logic                    PSLVERR
);

  localparam int unsigned STRB_WIDTH = DATA_WIDTH / 8;
  localparam int unsigned CNT_WIDTH  = timeout_cnt_width(TIMEOUT_CYCLES);
  localparam logic [CNT_WIDTH-1:0] CNT_LIMIT = CNT_WIDTH'(TIMEOUT_CYCLES);

  apb_state_e state_q, state_d;

  logic                  psel_q, psel_d;
  logic                  penable_q, penable_d;
  logic                  pwrite_q, pwrite_d;
  logic [ADDR_WIDTH-1:0] paddr_q, paddr_d;
  logic [DATA_WIDTH-1:0] pwdata_q, pwdata_d;
  logic [STRB_WIDTH-1:0] pstrb_q, pstrb_d;
  apb_prot_t             pprot_q, pprot_d;
  logic                  rsp_valid_q, rsp_valid_d;
  logic [DATA_WIDTH-1:0] rsp_rdata_q, rsp_rdata_d;
  logic                  rsp_err_q, rsp_err_d;
  logic                  rsp_timeout_q, rsp_timeout_d;

  logic cnt_clear, cnt_enable, cnt_expired;

  assign cnt_clear  = (state_q == SETUP);
  assign cnt_enable = (state_q == ACCESS) && !PREADY;

  apb_timeout_cnt #(
    .TIMEOUT_CYCLES (TIMEOUT_CYCLES),
    .CNT_WIDTH      (CNT_WIDTH)
  ) u_timeout_cnt (
    .clk     (PCLK),
    .rst_n   (PRESETn),
    .clear   (cnt_clear),
    .enable  (cnt_enable),
    .limit   (CNT_LIMIT),
    .expired (cnt_expired)
  );

  always_comb begin
    state_d       = state_q;
    psel_d        = psel_q;
    penable_d     = penable_q;
    pwrite_d      = pwrite_q;
    paddr_d       = paddr_q;
    pwdata_d      = pwdata_q;
    pstrb_d       = pstrb_q;
    pprot_d       = pprot_q;
    rsp_valid_d   = rsp_valid_q;
    rsp_rdata_d   = rsp_rdata_q;
    rsp_err_d     = rsp_err_q;
    rsp_timeout_d = rsp_timeout_q;

    unique case (state_q)
      IDLE: begin
        if (cmd_valid) begin
          state_d  = SETUP;
          psel_d   = 1'b1;
          paddr_d  = cmd_addr;
          pwrite_d = cmd_write;
          pwdata_d = cmd_wdata;
          // Reads must present all-zero strobes on the bus.
          pstrb_d  = cmd_write ? cmd_strb : '0;
          pprot_d  = cmd_prot;
        end
      end
      SETUP: begin
        state_d   = ACCESS;
        penable_d = 1'b1;
      end
      ACCESS: begin
        if (PREADY) begin
          state_d       = RESP;
          psel_d        = 1'b0;
          penable_d     = 1'b0;
          rsp_valid_d   = 1'b1;
          rsp_rdata_d   = pwrite_q ? '0 : PRDATA;
          rsp_err_d     = PSLVERR;
          rsp_timeout_d = 1'b0;
        end else if (cnt_expired) begin
          state_d       = RESP;
          psel_d        = 1'b0;
          penable_d     = 1'b0;
          rsp_valid_d   = 1'b1;
          rsp_rdata_d   = '0;
          rsp_err_d     = 1'b1;
          rsp_timeout_d = 1'b1;
        end
      end
      RESP: begin
        if (rsp_ready) begin
          state_d     = IDLE;
          rsp_valid_d = 1'b0;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge PCLK) begin
    if (!PRESETn) begin
      state_q       <= IDLE;
      psel_q        <= 1'b0;
      penable_q     <= 1'b0;
      pwrite_q      <= 1'b0;
      paddr_q       <= '0;
      pwdata_q      <= '0;
      pstrb_q       <= '0;
      pprot_q       <= '0;
      rsp_valid_q   <= 1'b0;
      rsp_rdata_q   <= '0;
      rsp_err_q     <= 1'b0;
      rsp_timeout_q <= 1'b0;
    end else begin
      state_q       <= state_d;
      psel_q        <= psel_d;
      penable_q     <= penable_d;
      pwrite_q      <= pwrite_d;
      paddr_q       <= paddr_d;
      pwdata_q      <= pwdata_d;
      pstrb_q       <= pstrb_d;
      pprot_q       <= pprot_d;
      rsp_valid_q   <= rsp_valid_d;
      rsp_rdata_q   <= rsp_rdata_d;
      rsp_err_q     <= rsp_err_d;
      rsp_timeout_q <= rsp_timeout_d;
    end
  end

  assign cmd_ready   = (state_q == IDLE);
  assign PSEL        = psel_q;
  assign PENABLE     = penable_q;
  assign PWRITE      = pwrite_q;
  assign PADDR       = paddr_q;
  assign PWDATA      = pwdata_q;
  assign PSTRB       = pstrb_q;
  assign PPROT       = pprot_q;
  assign rsp_valid   = rsp_valid_q;
  assign rsp_rdata   = rsp_rdata_q;
  assign rsp_err     = rsp_err_q;
  assign rsp_timeout = rsp_timeout_q;

endmodule

// File: tb/tb_apb_requester.sv
// Randomized bench: a reactive APB completer plus a transaction-level model of the
// expected response, latency and bus attributes for each command.
module tb_apb_requester;

  localparam int T = 4;

  logic        PCLK;
  logic        PRESETn;
  logic        cmd_valid;
  logic        cmd_ready;
  logic        cmd_write;
  logic [31:0] cmd_addr;
  logic [31:0] cmd_wdata;
  logic [3:0]  cmd_strb;
  logic [2:0]  cmd_prot;
  logic        rsp_valid;
  logic        rsp_ready;
  logic [31:0] rsp_rdata;
  logic        rsp_err;
  logic        rsp_timeout;
  logic [31:0] PADDR;
  logic        PSEL;
  logic        PENABLE;
  logic        PWRITE;
  logic [31:0] PWDATA;
  logic [3:0]  PSTRB;
  logic [2:0]  PPROT;
  logic [31:0] PRDATA;
  logic        PREADY;
  logic        PSLVERR;

  int n_vec = 0;
  int n_err = 0;

  apb_requester #(
    .ADDR_WIDTH     (32),
    .DATA_WIDTH     (32),
    .TIMEOUT_CYCLES (T)
  ) dut (
    .PCLK        (PCLK),
    .PRESETn     (PRESETn),
    .cmd_valid   (cmd_valid),
    .cmd_ready   (cmd_ready),
    .cmd_write   (cmd_write),
    .cmd_addr    (cmd_addr),
    .cmd_wdata   (cmd_wdata),
    .cmd_strb    (cmd_strb),
    .cmd_prot    (cmd_prot),
    .rsp_valid   (rsp_valid),
    .rsp_ready   (rsp_ready),
    .rsp_rdata   (rsp_rdata),
    .rsp_err     (rsp_err),
    .rsp_timeout (rsp_timeout),
    .PADDR       (PADDR),
    .PSEL        (PSEL),
    .PENABLE     (PENABLE),
    .PWRITE      (PWRITE),
    .PWDATA      (PWDATA),
    .PSTRB       (PSTRB),
    .PPROT       (PPROT),
    .PRDATA      (PRDATA),
    .PREADY      (PREADY),
    .PSLVERR     (PSLVERR)
  );

  initial PCLK = 1'b0;
  always #5 PCLK = ~PCLK;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached, got running expected finished");
    $fatal(1);
  end

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic scramble_cmd();
    cmd_valid = 1'($urandom_range(0, 1));
    cmd_write = 1'($urandom_range(0, 1));
    cmd_addr  = $urandom;
    cmd_wdata = $urandom;
    cmd_strb  = 4'($urandom);
    cmd_prot  = 3'($urandom);
  endtask

  task automatic do_reset();
    PRESETn = 1'b0;
    repeat (3) @(posedge PCLK);
    @(negedge PCLK);
    PRESETn = 1'b1;
  endtask

  // One full transfer. Called at a negedge with the DUT idle; returns at a negedge, idle.
  task automatic run_xfer(input logic wr, input logic [31:0] addr, input logic [31:0] wdata,
                          input logic [3:0] strb, input logic [2:0] prot, input int waits,
                          input logic err, input logic [31:0] rd, input int hold);
    logic        exp_to;
    int          exp_lat;
    int          exp_acc;
    logic [31:0] exp_rdata;
    logic        exp_err;
    logic [39:0] exp_attr;
    int          cyc;
    int          acc;
    bit          got;

    exp_to    = (T != 0) && (waits > T);
    exp_lat   = exp_to ? 3 + T : 3 + waits;
    exp_acc   = exp_to ? T + 1 : waits + 1;
    exp_rdata = (wr || exp_to) ? 32'h0 : rd;
    exp_err   = exp_to | err;
    exp_attr  = {wr, (wr ? strb : 4'h0), prot, wdata};

    check_eq("cmd_ready_idle", 64'(cmd_ready), 64'd1);
    cmd_valid = 1'b1;
    cmd_write = wr;
    cmd_addr  = addr;
    cmd_wdata = wdata;
    cmd_strb  = strb;
    cmd_prot  = prot;
    rsp_ready = 1'b0;
    @(posedge PCLK);

    cyc = 0;
    acc = 0;
    got = 1'b0;
    while (!got && cyc < exp_lat + 8) begin
      @(negedge PCLK);
      cyc++;
      scramble_cmd();
      PREADY  = 1'($urandom_range(0, 1));
      PSLVERR = 1'($urandom_range(0, 1));
      PRDATA  = $urandom;
      if (rsp_valid) begin
        got = 1'b1;
      end else if (PSEL) begin
        check_eq("apb_addr", 64'(PADDR), 64'(addr));
        check_eq("apb_attr", 64'({PWRITE, PSTRB, PPROT, PWDATA}), 64'(exp_attr));
        if (!PENABLE) begin
          check_eq("setup_cycle", 64'(cyc), 64'd1);
        end else begin
          if (acc == 0) check_eq("access_cycle", 64'(cyc), 64'd2);
          PREADY = (acc == waits);
          if (acc == waits) begin
            PRDATA  = rd;
            PSLVERR = err;
          end
          acc++;
        end
      end
    end

    check_eq("rsp_seen", 64'(got), 64'd1);
    if (!got) begin
      cmd_valid = 1'b0;
      do_reset();
      return;
    end
    check_eq("latency", 64'(cyc), 64'(exp_lat));
    check_eq("access_len", 64'(acc), 64'(exp_acc));
    check_eq("rsp_rdata", 64'(rsp_rdata), 64'(exp_rdata));
    check_eq("rsp_flags", 64'({rsp_err, rsp_timeout}), 64'({exp_err, exp_to}));
    check_eq("bus_idle_rsp", 64'({PSEL, PENABLE, cmd_ready}), 64'd0);

    for (int h = 0; h < hold; h++) begin
      @(posedge PCLK);
      @(negedge PCLK);
      scramble_cmd();
      PREADY = 1'($urandom_range(0, 1));
      check_eq("rsp_hold", 64'({rsp_valid, rsp_err, rsp_timeout, rsp_rdata}),
               64'({1'b1, exp_err, exp_to, exp_rdata}));
      check_eq("hold_busy", 64'({cmd_ready, PSEL}), 64'd0);
    end

    rsp_ready = 1'b1;
    cmd_valid = 1'b0;
    @(posedge PCLK);
    @(negedge PCLK);
    rsp_ready = 1'b0;
    check_eq("rsp_done", 64'({rsp_valid, cmd_ready, PSEL}), 64'b010);
    check_eq("addr_held", 64'(PADDR), 64'(addr));
  endtask

  task automatic run_reset_mid();
    logic [31:0] addr;
    addr      = $urandom;
    cmd_valid = 1'b1;
    cmd_write = 1'b0;
    cmd_addr  = addr;
    cmd_strb  = 4'hF;
    PREADY    = 1'b0;
    @(posedge PCLK);
    @(negedge PCLK);
    cmd_valid = 1'b0;
    @(negedge PCLK);
    check_eq("rst_mid_access", 64'({PSEL, PENABLE}), 64'b11);
    PRESETn = 1'b0;
    @(posedge PCLK);
    @(negedge PCLK);
    check_eq("rst_mid_bus", 64'({PSEL, PENABLE, rsp_valid}), 64'd0);
    check_eq("rst_mid_addr", 64'(PADDR), 64'd0);
    PRESETn = 1'b1;
    for (int i = 0; i < 6; i++) begin
      PREADY  = 1'b1;
      PSLVERR = 1'($urandom_range(0, 1));
      @(posedge PCLK);
      @(negedge PCLK);
      check_eq("rst_mid_quiet", 64'({rsp_valid, PSEL, cmd_ready}), 64'b001);
    end
    PREADY = 1'b0;
  endtask

  initial begin
    cmd_valid = 1'b0;
    cmd_write = 1'b0;
    cmd_addr  = '0;
    cmd_wdata = '0;
    cmd_strb  = '0;
    cmd_prot  = '0;
    rsp_ready = 1'b0;
    PRDATA    = '0;
    PREADY    = 1'b0;
    PSLVERR   = 1'b0;
    PRESETn   = 1'b0;
    repeat (3) @(posedge PCLK);
    @(negedge PCLK);
    check_eq("rst_ctrl", 64'({PSEL, PENABLE, PWRITE, rsp_valid, rsp_err, rsp_timeout}), 64'd0);
    check_eq("rst_addr", 64'(PADDR), 64'd0);
    check_eq("rst_data", 64'({PWDATA, PSTRB, PPROT}), 64'd0);
    check_eq("rst_rdata", 64'(rsp_rdata), 64'd0);
    check_eq("rst_cmd_ready", 64'(cmd_ready), 64'd1);
    PRESETn = 1'b1;
    @(negedge PCLK);

    run_xfer(1'b1, 32'h0000_0010, 32'hDEAD_BEEF, 4'hF, 3'b000, 0, 1'b0, 32'h5555_AAAA, 0);
    run_xfer(1'b0, 32'h0000_0024, 32'h0BAD_F00D, 4'hF, 3'b001, 3, 1'b0, 32'h1234_5678, 0);
    run_xfer(1'b0, 32'h0000_0030, 32'h0, 4'h3, 3'b010, 1, 1'b1, 32'hA5A5_5A5A, 0);
    run_xfer(1'b0, 32'h0000_0040, 32'h0, 4'hF, 3'b100, 20, 1'b0, 32'h7777_7777, 0);
    run_xfer(1'b0, 32'h0000_0044, 32'h0, 4'hF, 3'b000, T, 1'b0, 32'h0F0F_F0F0, 0);
    run_xfer(1'b1, 32'h0000_0048, 32'h1111_2222, 4'h5, 3'b011, T + 1, 1'b1, 32'h0, 0);
    run_xfer(1'b0, 32'h0000_0050, 32'h0, 4'hF, 3'b111, 0, 1'b0, 32'hCAFE_F00D, 5);
    run_reset_mid();

    for (int i = 0; i < 60; i++) begin
      run_xfer(1'($urandom_range(0, 1)), $urandom, $urandom, 4'($urandom), 3'($urandom),
               int'($urandom_range(0, 7)), ($urandom_range(0, 3) == 0), $urandom,
               int'($urandom_range(0, 3)));
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
